// File: rtl/hsv_arb_pkg.sv
// Shared widths, hue limit and FSM state type for the HSV converter arbiter.
package hsv_arb_pkg;

  localparam int H_W   = 11;
  localparam int SV_W  = 8;
  localparam int RGB_W = 24;

  localparam logic [H_W-1:0] HUE_MAX = 11'h5FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Hue codes above HUE_MAX are pinned to HUE_MAX.
  function automatic logic [H_W-1:0] clamp_hue(input logic [H_W-1:0] h);
    return (h > HUE_MAX) ? HUE_MAX : h;
  endfunction

endpackage

// File: rtl/hsv_rr_pick.sv
// Combinational round-robin picker: first active request above i_last, wrapping.
module hsv_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // k walks the priority order last+1, last+2, ... ; i names the matching slot.
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!o_any && (((int'(i_last) + k) % N) == i) && i_req[i]) begin
          o_gnt[i] = 1'b1;
          o_idx    = IW'(i);
          o_any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hsv_conv_arbiter.sv
// Round-robin sharing of one HSV->RGB converter among NUM_REQ requesters,
// with hue clamping, fixed converter latency wait and id-tagged result.
module hsv_conv_arbiter
  import hsv_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int CONV_LAT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [H_W*NUM_REQ-1:0]  req_h,
  input  logic [SV_W*NUM_REQ-1:0] req_s,
  input  logic [SV_W*NUM_REQ-1:0] req_v,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [15:0]             conv_h,
  output logic [SV_W-1:0]         conv_s,
  output logic [SV_W-1:0]         conv_v,
  input  logic [RGB_W-1:0]        conv_rgb,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_id,
  output logic [RGB_W-1:0]        rsp_rgb,
  output logic [1:0]              dbg_state
);

  arb_state_e       r_state, w_next;
  logic [1:0]       r_last, r_cnt, r_pend_id, r_rsp_id;
  logic [H_W-1:0]   r_conv_h;
  logic [SV_W-1:0]  r_conv_s, r_conv_v;
  logic [RGB_W-1:0] r_rsp_rgb;

  logic [NUM_REQ-1:0] w_gnt;
  logic [1:0]         w_idx;
  logic               w_any, w_grant_en, w_accept;
  logic [H_W-1:0]     w_h_sel;
  logic [SV_W-1:0]    w_s_sel, w_v_sel;

  hsv_rr_pick #(.N(NUM_REQ), .IW(2)) u_pick (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Handshake: requester i transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; ready is one-hot, never high in BUSY, and a
  // requester may withdraw valid before it is granted.
  assign w_grant_en = (r_state != BUSY);
  assign w_accept   = w_grant_en & w_any;
  assign req_ready  = w_grant_en ? w_gnt : '0;

  always_comb begin
    w_h_sel = '0;
    w_s_sel = '0;
    w_v_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_h_sel = req_h[i*H_W +: H_W];
        w_s_sel = req_s[i*SV_W +: SV_W];
        w_v_sel = req_v[i*SV_W +: SV_W];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RESP: w_next = w_any ? BUSY : IDLE;
      BUSY:       if (r_cnt == 2'd0) w_next = RESP;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last    <= 2'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_pend_id <= '0;
      r_conv_h  <= '0;
      r_conv_s  <= '0;
      r_conv_v  <= '0;
      r_rsp_id  <= '0;
      r_rsp_rgb <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_conv_h  <= clamp_hue(w_h_sel);
        r_conv_s  <= w_s_sel;
        r_conv_v  <= w_v_sel;
        r_pend_id <= w_idx;
        r_last    <= w_idx;
        r_cnt     <= 2'(CONV_LAT);
      end
      if (r_state == BUSY) begin
        if (r_cnt != 2'd0) begin
          r_cnt <= r_cnt - 2'd1;
        end else begin
          r_rsp_rgb <= conv_rgb;
          r_rsp_id  <= r_pend_id;
        end
      end
    end
  end

  assign conv_h    = {5'b0, r_conv_h};
  assign conv_s    = r_conv_s;
  assign conv_v    = r_conv_v;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_rgb   = r_rsp_rgb;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hsv_conv_arbiter.sv
// Directed bench: three arbiter instances (CONV_LAT 0, 2, 3) with stub converters.
module tb_hsv_conv_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance L0: CONV_LAT = 0
  logic        rst_n0;
  logic [2:0]  v0, rdy0;
  logic [32:0] h0;
  logic [23:0] s0, vv0, crgb0, rgb0;
  logic [15:0] ch0;
  logic [7:0]  cs0, cv0;
  logic        rv0;
  logic [1:0]  rid0, dbg0;

  // Instance L2: CONV_LAT = 2
  logic        rst_n2;
  logic [2:0]  v2, rdy2;
  logic [32:0] h2;
  logic [23:0] s2, vv2, crgb2, rgb2, p2a, p2b;
  logic [15:0] ch2;
  logic [7:0]  cs2, cv2;
  logic        rv2;
  logic [1:0]  rid2, dbg2;

  // Instance L3: CONV_LAT = 3
  logic        rst_n3;
  logic [2:0]  v3, rdy3;
  logic [32:0] h3;
  logic [23:0] s3, vv3, crgb3, rgb3, p3a, p3b, p3c;
  logic [15:0] ch3;
  logic [7:0]  cs3, cv3;
  logic        rv3;
  logic [1:0]  rid3, dbg3;

  // Stub converters return {h[7:0], s, v} after CONV_LAT register stages.
  assign crgb0 = {ch0[7:0], cs0, cv0};
  always @(posedge clk) begin
    p2a <= {ch2[7:0], cs2, cv2};
    p2b <= p2a;
    p3a <= {ch3[7:0], cs3, cv3};
    p3b <= p3a;
    p3c <= p3b;
  end
  assign crgb2 = p2b;
  assign crgb3 = p3c;

  hsv_conv_arbiter #(.NUM_REQ(3), .CONV_LAT(0)) u_l0 (
    .clk(clk), .reset(rst_n0), .req_valid(v0), .req_h(h0), .req_s(s0), .req_v(vv0),
    .req_ready(rdy0), .conv_h(ch0), .conv_s(cs0), .conv_v(cv0), .conv_rgb(crgb0),
    .rsp_valid(rv0), .rsp_id(rid0), .rsp_rgb(rgb0), .dbg_state(dbg0)
  );

  hsv_conv_arbiter #(.NUM_REQ(3), .CONV_LAT(2)) u_l2 (
    .clk(clk), .reset(rst_n2), .req_valid(v2), .req_h(h2), .req_s(s2), .req_v(vv2),
    .req_ready(rdy2), .conv_h(ch2), .conv_s(cs2), .conv_v(cv2), .conv_rgb(crgb2),
    .rsp_valid(rv2), .rsp_id(rid2), .rsp_rgb(rgb2), .dbg_state(dbg2)
  );

  hsv_conv_arbiter #(.NUM_REQ(3), .CONV_LAT(3)) u_l3 (
    .clk(clk), .reset(rst_n3), .req_valid(v3), .req_h(h3), .req_s(s3), .req_v(vv3),
    .req_ready(rdy3), .conv_h(ch3), .conv_s(cs3), .conv_v(cv3), .conv_rgb(crgb3),
    .rsp_valid(rv3), .rsp_id(rid3), .rsp_rgb(rgb3), .dbg_state(dbg3)
  );

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rdy0 !== 3'b000) $display("FAIL rst_ready got=%b exp=000", rdy0); else n_pass++;
    n_checks++; if (ch0 !== 16'h0) $display("FAIL rst_conv_h got=%h exp=0000", ch0); else n_pass++;
    n_checks++; if (cs0 !== 8'h0) $display("FAIL rst_conv_s got=%h exp=00", cs0); else n_pass++;
    n_checks++; if (cv0 !== 8'h0) $display("FAIL rst_conv_v got=%h exp=00", cv0); else n_pass++;
    n_checks++; if (rv0 !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", rv0); else n_pass++;
    n_checks++; if (rid0 !== 2'd0) $display("FAIL rst_rsp_id got=%0d exp=0", rid0); else n_pass++;
    n_checks++; if (rgb0 !== 24'h0) $display("FAIL rst_rsp_rgb got=%h exp=000000", rgb0); else n_pass++;
    @(posedge clk); #1 rst_n0 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++; if (rdy0 !== 3'b000) $display("FAIL idle_ready c=%0d got=%b exp=000", c, rdy0); else n_pass++;
      n_checks++; if (rv0 !== 1'b0) $display("FAIL idle_rsp_valid c=%0d got=%b exp=0", c, rv0); else n_pass++;
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    v0 = 3'b010; h0[11 +: 11] = 11'h100; s0[8 +: 8] = 8'hFF; vv0[8 +: 8] = 8'hFF;
    @(negedge clk);
    n_checks++; if (rdy0 !== 3'b010) $display("FAIL single_ready got=%b exp=010", rdy0); else n_pass++;
    @(posedge clk); #1 v0 = 3'b000;
    @(negedge clk);
    n_checks++; if (ch0 !== 16'h0100) $display("FAIL single_conv_h got=%h exp=0100", ch0); else n_pass++;
    n_checks++; if (rdy0 !== 3'b000) $display("FAIL single_busy_ready got=%b exp=000", rdy0); else n_pass++;
    n_checks++; if (rv0 !== 1'b0) $display("FAIL single_early_rsp got=%b exp=0", rv0); else n_pass++;
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b1) $display("FAIL single_rsp_valid got=%b exp=1", rv0); else n_pass++;
    n_checks++; if (rid0 !== 2'd1) $display("FAIL single_rsp_id got=%0d exp=1", rid0); else n_pass++;
    n_checks++; if (rgb0 !== 24'h00FFFF) $display("FAIL single_rsp_rgb got=%h exp=00ffff", rgb0); else n_pass++;
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b0) $display("FAIL single_strobe_len got=%b exp=0", rv0); else n_pass++;
    n_checks++; if (rgb0 !== 24'h00FFFF) $display("FAIL single_rgb_hold got=%h exp=00ffff", rgb0); else n_pass++;
  endtask

  task automatic clamp_case(input logic [10:0] h, input logic [15:0] exp_h);
    logic [23:0] exp_rgb;
    exp_rgb = {exp_h[7:0], 8'h5A, 8'hA5};
    @(posedge clk); #1;
    v0 = 3'b001; h0[0 +: 11] = h; s0[0 +: 8] = 8'h5A; vv0[0 +: 8] = 8'hA5;
    @(negedge clk);
    n_checks++; if (rdy0 !== 3'b001) $display("FAIL clamp_ready h=%h got=%b exp=001", h, rdy0); else n_pass++;
    @(posedge clk); #1 v0 = 3'b000;
    @(negedge clk);
    n_checks++; if (ch0 !== exp_h) $display("FAIL clamp_conv_h h=%h got=%h exp=%h", h, ch0, exp_h); else n_pass++;
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b1 || rgb0 !== exp_rgb)
      $display("FAIL clamp_rsp h=%h got=%b/%h exp=1/%h", h, rv0, rgb0, exp_rgb); else n_pass++;
  endtask

  task automatic test_clamp();
    clamp_case(11'h7FF, 16'h05FF);
    clamp_case(11'h5FF, 16'h05FF);
    clamp_case(11'h000, 16'h0000);
    clamp_case(11'h600, 16'h05FF);
  endtask

  task automatic test_rotation();
    logic [1:0]  exp_q[$];
    logic [23:0] exp_rgb [3];
    int          g_id [6];
    int          g_cyc [6];
    int          ng, nr, busy_viol, gi;
    logic [1:0]  e;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    exp_rgb[0] = 24'h111001; exp_rgb[1] = 24'h222002; exp_rgb[2] = 24'h333003;
    ng = 0; nr = 0; busy_viol = 0;
    @(posedge clk); #1;
    h2 = {11'h033, 11'h022, 11'h011};
    s2 = {8'h30, 8'h20, 8'h10};
    vv2 = {8'h03, 8'h02, 8'h01};
    v2 = 3'b111; rst_n2 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dbg2 == 2'd1 && rdy2 !== 3'b000) busy_viol++;
      if (rdy2 !== 3'b000 && ng < 6) begin
        case (rdy2)
          3'b001:  gi = 0;
          3'b010:  gi = 1;
          3'b100:  gi = 2;
          default: gi = -1;
        endcase
        g_id[ng] = gi; g_cyc[ng] = c; ng++;
      end
      if (rv2 === 1'b1 && nr < 6) begin
        e = exp_q.pop_front();
        n_checks++; if (rid2 !== e) $display("FAIL rot_rsp_id n=%0d got=%0d exp=%0d", nr, rid2, e); else n_pass++;
        n_checks++; if (rgb2 !== exp_rgb[e]) $display("FAIL rot_rsp_rgb n=%0d got=%h exp=%h", nr, rgb2, exp_rgb[e]); else n_pass++;
        nr++;
      end
    end
    @(posedge clk); #1 v2 = 3'b000;
    n_checks++; if (busy_viol !== 0) $display("FAIL rot_ready_in_busy got=%0d exp=0", busy_viol); else n_pass++;
    n_checks++; if (ng !== 6) $display("FAIL rot_grant_count got=%0d exp=6", ng); else n_pass++;
    n_checks++; if (nr !== 6) $display("FAIL rot_rsp_count got=%0d exp=6", nr); else n_pass++;
    for (int i = 0; i < ng; i++) begin
      n_checks++; if (g_id[i] !== i % 3) $display("FAIL rot_order n=%0d got=%0d exp=%0d", i, g_id[i], i % 3); else n_pass++;
      if (i > 0) begin
        n_checks++; if (g_cyc[i] - g_cyc[i-1] !== 4)
          $display("FAIL rot_spacing n=%0d got=%0d exp=4", i, g_cyc[i] - g_cyc[i-1]); else n_pass++;
      end
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    bit found;
    found = 1'b0;
    @(posedge clk); #1 v2 = 3'b100;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (rdy2 !== 3'b000) found = 1'b1;
    end
    n_checks++; if (!found || rdy2 !== 3'b100) $display("FAIL b2b_first_grant got=%b exp=100", rdy2); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      repeat (4) @(negedge clk);
      n_checks++; if (rv2 !== 1'b1) $display("FAIL b2b_rsp_valid k=%0d got=%b exp=1", k, rv2); else n_pass++;
      n_checks++; if (rid2 !== 2'd2) $display("FAIL b2b_rsp_id k=%0d got=%0d exp=2", k, rid2); else n_pass++;
      n_checks++; if (rdy2 !== 3'b100) $display("FAIL b2b_regrant k=%0d got=%b exp=100", k, rdy2); else n_pass++;
    end
    @(posedge clk); #1 v2 = 3'b000;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int early;
    early = 0;
    @(posedge clk); #1;
    h3 = {11'h1EE, 11'h0C3, 11'h0AB};
    s3 = {8'h66, 8'h44, 8'h12};
    vv3 = {8'h77, 8'h55, 8'h34};
    rst_n3 = 1'b1; v3 = 3'b010;
    @(negedge clk);
    n_checks++; if (rdy3 !== 3'b010) $display("FAIL rm_first_ready got=%b exp=010", rdy3); else n_pass++;
    @(posedge clk); #1 v3 = 3'b000;
    repeat (5) @(negedge clk);
    n_checks++; if (rv3 !== 1'b1 || rid3 !== 2'd1 || rgb3 !== 24'hC34455)
      $display("FAIL rm_first_rsp got=%b/%0d/%h exp=1/1/c34455", rv3, rid3, rgb3); else n_pass++;
    @(posedge clk); #1 v3 = 3'b010;
    @(negedge clk);
    n_checks++; if (rdy3 !== 3'b010) $display("FAIL rm_second_ready got=%b exp=010", rdy3); else n_pass++;
    @(posedge clk); #1 v3 = 3'b000; rst_n3 = 1'b0;
    @(negedge clk); if (rv3 !== 1'b0) early++;
    @(posedge clk);
    @(negedge clk); if (rv3 !== 1'b0) early++;
    @(posedge clk); #1 rst_n3 = 1'b1; v3 = 3'b111;
    @(negedge clk);
    n_checks++; if (rdy3 !== 3'b001) $display("FAIL rm_regrant got=%b exp=001", rdy3); else n_pass++;
    n_checks++; if (rgb3 !== 24'h0 || rid3 !== 2'd0) $display("FAIL rm_cleared got=%h/%0d exp=000000/0", rgb3, rid3); else n_pass++;
    @(posedge clk); #1 v3 = 3'b000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rv3 !== 1'b0 || rgb3 !== 24'h0) early++;
    end
    n_checks++; if (early !== 0) $display("FAIL rm_aborted_rsp got=%0d exp=0", early); else n_pass++;
    @(negedge clk);
    n_checks++; if (rv3 !== 1'b1 || rid3 !== 2'd0 || rgb3 !== 24'hAB1234)
      $display("FAIL rm_after_rsp got=%b/%0d/%h exp=1/0/ab1234", rv3, rid3, rgb3); else n_pass++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n0 = 1'b0; rst_n2 = 1'b0; rst_n3 = 1'b0;
    v0 = '0; h0 = '0; s0 = '0; vv0 = '0;
    v2 = '0; h2 = '0; s2 = '0; vv2 = '0;
    v3 = '0; h3 = '0; s3 = '0; vv3 = '0;
    test_reset();
    test_single();
    test_clamp();
    test_rotation();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hsv_conv_arbiter.md
# hsv_conv_arbiter

Round-robin arbiter that shares one `__hsv2rgb__hsv2rgb` converter among up to `NUM_REQ` HSV requesters, e.g. several encoder-driven mixers or LED channels on one die. It accepts an HSV triple from one requester at a time and clamps hue to the legal range. It drives the shared converter, waits out its configured latency, and returns the 24-bit RGB result tagged with the requester index.

## Interface
- `NUM_REQ`, 3: number of requesters; 2..4.
- `CONV_LAT`, 0: converter register stages between `conv_*` and `conv_rgb`; 0..3. Use 0 for the combinational converter.
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request.
- `req_h` in 11*NUM_REQ: packed hue; requester i occupies bits [11i+10:11i].
- `req_s` in 8*NUM_REQ: packed saturation.
- `req_v` in 8*NUM_REQ: packed value.
- `req_ready` out NUM_REQ: one-hot grant. Transfer occurs on a cycle where `req_valid[i] & req_ready[i]`.
- `conv_h` out 16: to the converter; `{5'b0, clamped hue}`.
- `conv_s` out 8: to the converter.
- `conv_v` out 8: to the converter.
- `conv_rgb` in 24: from the converter; {r,g,b}.
- `rsp_valid` out 1: one-cycle result strobe.
- `rsp_id` out 2: index of the requester that owns the result.
- `rsp_rgb` out 24: result; held until the next `rsp_valid`.

## Operation
- FSM states: IDLE, BUSY, RESP.
  - IDLE/RESP with any `req_valid` → grant, then BUSY.
  - IDLE/RESP with no `req_valid` → IDLE.
  - BUSY with wait counter == 0 → RESP.
- Grant is combinational in IDLE/RESP: `req_ready` is one-hot on the first valid requester, searching upward from `last+1 mod NUM_REQ`. `last` is the index of the most recent grant.
- `req_ready` is all-zero in BUSY, and all-zero when no requester is valid.
- On the accept edge, the block:
  - latches `conv_h/s/v`,
  - latches `rsp_id` into a pending id register,
  - updates `last`,
  - loads the wait counter with `CONV_LAT`.
- Hue clamp: a hue above 11'h5FF is sent as 11'h5FF; otherwise it passes unchanged. S and V pass unchanged.
- In BUSY:
  - counter > 0 → decrement.
  - counter == 0 → sample `conv_rgb` into `rsp_rgb`, move the pending id to `rsp_id`, and go to RESP.
- RESP lasts one cycle, with `rsp_valid`=1. A new grant may issue in that same cycle (back-to-back).
- `conv_*` hold their last value between transactions.
- Requesters hold their h/s/v stable while `req_valid` is high and no grant has occurred. A requester may drop `req_valid` before it is granted; no transfer occurs in that case.
- `reset`=0 mid-transaction aborts it: no `rsp_valid` is issued for the in-flight request.
- Reset values:
  - State = IDLE.
  - `last` = NUM_REQ-1, so requester 0 wins first.
  - `req_ready`, `conv_h/s/v`, `rsp_valid`, `rsp_id` and `rsp_rgb` all = 0.

## Timing
- Accept edge E: BUSY occupies cycles E..E+CONV_LAT. `rsp_valid` is high in cycle E+CONV_LAT+1.
- Sustained throughput is one conversion per CONV_LAT+2 cycles.
- `conv_*` change only on accept edges. This keeps them stable for the whole BUSY window, which meets the converter's input-hold requirement for any `CONV_LAT`.
- `req_ready` depends combinationally on `req_valid` and state. No other output has a combinational input→output path.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,… Maximum wait is (NUM_REQ-1)·(CONV_LAT+2) cycles.

## Structure
- Package `hsv_arb_pkg` holds:
  - `HUE_MAX` = 11'h5FF,
  - widths `H_W`=11, `SV_W`=8, `RGB_W`=24,
  - the state enum {IDLE, BUSY, RESP}.
- Sub-module `hsv_rr_pick`: parameterised round-robin priority picker. Inputs are the request vector and `last`; outputs are the one-hot grant and the binary index. It is purely combinational.
- The top level contains the FSM, wait counter, input mux and clamp, and result registers.

## Test plan
- Reset hold, then release with no requests → all outputs 0 and `req_ready`=000 indefinitely.
- Single request, CONV_LAT=0: req 1 with h=0x100, s=0xFF, v=0xFF; stub converter returns {h[7:0],s,v}.
  - Expected: `req_ready`=010 for one cycle, `conv_h`=0x0100, then `rsp_valid` 2 cycles after accept with `rsp_id`=1 and `rsp_rgb`=0x00FFFF.
- Clamp: h=0x7FF.
  - Expected: `conv_h`=0x05FF; h=0x5FF passes as 0x05FF; h=0x000 passes as 0x0000.
- All three requesters always valid, CONV_LAT=2.
  - Expected: grant order 0,1,2,0,1,2, one grant every 4 cycles.
  - `rsp_id` sequence matches the grant order.
  - `req_ready` is never asserted during BUSY.
- Back-to-back: req 2 keeps `req_valid` high after its grant.
  - Expected: its next grant lands in the same cycle as the previous `rsp_valid`.
- Reset asserted in the middle of BUSY (CONV_LAT=3).
  - Expected: no `rsp_valid` appears.
  - After release, the first grant goes to requester 0; `rsp_rgb`=0 until the next result.
